// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Radix-2 shift-add multiply and restoring shift-subtract divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: special cases (div by zero, signed overflow,
// multiply by zero) skip the iteration phase and complete 2 cycles after start.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, flush    request (sampled when idle) / synchronous abort
//   funct3          operation select
//   a, b            rs1 / rs2 operands, sampled with start
//   busy, done      operation in flight / one-cycle completion pulse
//   result          last completed result, valid with done and held afterwards
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned W  = XLEN;
  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = 6;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [W-1:0]    op_a_q, op_a_d;     // multiplier / dividend-then-quotient
  logic [W-1:0]    op_b_q, op_b_d;     // multiplicand / divisor
  logic [W2-1:0]   acc_q, acc_d;       // product, or {remainder, -}
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;       // effective operand signs differ
  logic            sgn_a_q, sgn_a_d;   // effective dividend sign
  logic            fix_ph_q, fix_ph_d; // FIX: 0 = sign correction, 1 = result write
  logic            spec_q, spec_d;
  logic [W-1:0]    spec_val_q, spec_val_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    result_q, result_d;

  // Start-time operand decode
  logic         a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0] abs_a, abs_b;
  logic         div_zero, div_ovf, mul_zero, special;
  logic [W-1:0] special_val;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = a_signed & a[W-1];
    sign_b   = b_signed & b[W-1];
    abs_a    = sign_a ? W'(~a + W'(1)) : a;
    abs_b    = sign_b ? W'(~b + W'(1)) : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    mul_zero = !funct3[2] && ((a == '0) || (b == '0));
    special  = div_zero || div_ovf || mul_zero;
    if (div_zero)     special_val = funct3[1] ? a : '1;
    else if (div_ovf) special_val = funct3[1] ? '0 : a;
    else              special_val = '0;
  end

  // Datapath step terms
  logic [W:0]   mul_sum;
  logic [W:0]   rem_sh;
  logic [W+1:0] rem_diff;
  logic [W-1:0] quot_fix, rem_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:W]} + (op_a_q[0] ? {1'b0, op_b_q} : (W+1)'(0));
    rem_sh   = {acc_q[W2-1:W], op_a_q[W-1]};
    // Extra top bit keeps the borrow when the shifted remainder exceeds 32 bits
    rem_diff = {1'b0, rem_sh} - {2'b00, op_b_q};
    quot_fix = neg_q   ? W'(~op_a_q + W'(1)) : op_a_q;
    rem_fix  = sgn_a_q ? W'(~acc_q[W2-1:W] + W'(1)) : acc_q[W2-1:W];
  end

  // Next-state and register update logic
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    sgn_a_d    = sgn_a_q;
    fix_ph_d   = fix_ph_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d       = funct3;
          op_a_d     = abs_a;
          op_b_d     = abs_b;
          neg_d      = sign_a ^ sign_b;
          sgn_a_d    = sign_a;
          acc_d      = '0;
          spec_d     = special;
          spec_val_d = special_val;
          fix_ph_d   = 1'b0;
          if (EARLY_OUT && special) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(32);
          end
        end
      end
      S_CALC: begin
        if (!f3_q[2]) begin
          acc_d  = {mul_sum, acc_q[W-1:1]};
          op_a_d = op_a_q >> 1;
        end else begin
          acc_d[W2-1:W] = rem_diff[W+1] ? rem_sh[W-1:0] : rem_diff[W-1:0];
          op_a_d        = {op_a_q[W-2:0], ~rem_diff[W+1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_FIX;
          fix_ph_d = 1'b0;
        end
      end
      S_FIX: begin
        if (!fix_ph_q) begin
          if (f3_q[2]) acc_d = {rem_fix, quot_fix};
          else if (neg_q) acc_d = W2'(~acc_q + W2'(1));
          fix_ph_d = 1'b1;
        end else begin
          if (spec_q)                    result_d = spec_val_q;
          else if (!f3_q[2])             result_d = (f3_q[1:0] == 2'b00) ? acc_q[W-1:0] : acc_q[W2-1:W];
          else                           result_d = f3_q[1] ? acc_q[W2-1:W] : acc_q[W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a simultaneous start
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      sgn_a_q    <= 1'b0;
      fix_ph_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      sgn_a_q    <= sgn_a_d;
      fix_ph_q   <= fix_ph_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative M-extension execution unit for the RV32IM core. Sits beside the single-cycle ALU in the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per start/done handshake and computes it with a radix-2 shift-add / restoring shift-subtract datapath. The pipeline controller stalls on `busy` and takes `result` when `done` pulses.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `busy`=0.
- `flush` input 1: synchronous abort of the in-flight operation.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input 32: rs1 operand, sampled with `start`.
- `b` input 32: rs2 operand, sampled with `start`.
- `busy` output 1: operation in flight; new `start` is ignored.
- `done` output 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` output 32: last completed result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC on `start` with `flush`=0. On this edge:
  - latch `funct3`;
  - latch absolute values of signed operands and their sign bits. MULH: both signed. MULHSU: `a` signed, `b` unsigned. DIV/REM: both signed.
  - clear the 64-bit accumulator/remainder;
  - load the 6-bit iteration counter with 32.
- CALC: one iteration per cycle; counter decrements; → FIX when the counter reaches 0 after the 32nd iteration.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the accumulator upper half; then shift right 1. Use a 33-bit add to keep the carry.
  - Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem (33-bit). If the result is non-negative, commit it and set the quotient LSB.
- FIX: apply sign correction.
  - Product: negate the 64-bit product if the operand signs differ (signed operands only). MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Write `result`; → DONE.
- DONE: `done`=1 for exactly this cycle; → IDLE.
- `busy`=1 in CALC, FIX and DONE; `busy`=0 in IDLE.
- RISC-V special cases, checked at start and producing no trap:
  - divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = `a`.
  - signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- `flush`=1 in any state: the next edge goes to IDLE with no `done` and `result` unchanged.
- `flush` and `start` in the same cycle: `flush` wins and the operation is not accepted.
- `start` while `busy`=1: ignored, no queueing.
- Reset (async, any state): state IDLE, `busy`=0, `done`=0, `result`=0, counter 0. An in-flight operation is lost.

## Timing
- Call E0 the rising edge that samples `start`.
- Iterative path: `done`=1 in the cycle following edge E0+34. Breakdown: 32 CALC edges, 1 FIX edge, 1 DONE entry. Total is 34 cycles start-to-done.
- `busy` rises in the cycle after E0 and falls in the cycle after `done`. The earliest next `start` is sampled on the edge that ends the `done` cycle plus one, i.e. when `busy`=0 in IDLE.
- `result` changes only on the edge entering DONE.
- Operands may change after E0 without effect.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - divide-by-zero, signed overflow, and multiply with either operand 0 bypass CALC;
  - IDLE → FIX at E0 with the precomputed result;
  - `done` in the cycle after E0+2.
- Undefined: the same special results are produced, but always via the full 34-cycle path. The special result is forced in FIX.
- Results are identical either way; only latency differs.

## Test plan
- MUL `a`=7, `b`=6 → `result`=0x0000002A with `done` exactly 34 cycles after start. `busy` is high for the whole window.
- MULH `a`=0xFFFFFFFF (−1), `b`=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU `a`=0xFFFFFFFF, `b`=2 → 0xFFFFFFFF.
- DIV `a`=−7 (0xFFFFFFF9), `b`=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU `a`=100, `b`=7 → 14; REMU → 2.
- DIVU `a`=5, `b`=0 → 0xFFFFFFFF; REM `a`=5, `b`=0 → 5; DIV `a`=0x80000000, `b`=0xFFFFFFFF → 0x80000000.
  - With `MULDIV_EARLY_OUT_EN`: `done` 2 cycles after start.
  - Without it: `done` 34 cycles after start.
- Start DIVU 100/7; assert `flush` 10 cycles later → no `done`, `busy`=0 next cycle, `result` keeps its previous value. A second `start` pulsed mid-operation (cycle 5) is ignored.
- Deassert `rst_n` asynchronously mid-CALC → `busy`, `done`, `result` go to 0 immediately. After release, MUL 3×3 → 9 with normal latency.
